// File: rtl/config_loader.sv
// Streams a word-organised bitstream into a serial configuration chain, one bit per
// strobe, clearing the chain first and checking the chain's return path stays at zero.
module config_loader #(
  parameter int WORD      = 32,
  parameter int CHAIN_LEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [WORD-1:0] word_in,
  input  logic            word_valid,
  output logic            word_ready,
  output logic            chain_out,
  output logic            chain_shift,
  output logic            chain_reset,
  input  logic            chain_ret,
  output logic            busy,
  output logic            done,
  output logic            error
);

  localparam int NW  = (CHAIN_LEN + WORD - 1) / WORD;
  localparam int BIW = (WORD > 1) ? $clog2(WORD) : 1;
  localparam int WCW = $clog2(NW + 1);
  localparam int BCW = $clog2(CHAIN_LEN + 1);

  localparam logic [BIW-1:0] LAST_IDX  = BIW'(WORD - 1);
  localparam logic [WCW-1:0] NW_CNT    = WCW'(NW);
  localparam logic [BCW-1:0] FINAL_BIT = BCW'(CHAIN_LEN - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    LOAD   = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t          state_r;
  state_t          next_state_s;
  logic [WORD-1:0] hold_r;
  logic            hold_valid_r;
  logic [BIW-1:0]  bit_idx_r;
  logic [WCW-1:0]  words_r;
  logic [BCW-1:0]  bits_r;
  logic            error_r;
  logic            strobe_s;
  logic            last_in_hold_s;
  logic            accept_s;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and output decode; all outputs depend only on registered state
  always_comb begin
    next_state_s   = state_r;
    strobe_s       = 1'b0;
    last_in_hold_s = 1'b0;
    word_ready     = 1'b0;
    chain_out      = 1'b0;
    chain_reset    = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = CLEAR;
        end else begin
          next_state_s = IDLE;
        end
      end
      CLEAR: begin
        chain_reset  = 1'b1;
        busy         = 1'b1;
        next_state_s = LOAD;
      end
      LOAD: begin
        busy = 1'b1;
        if (hold_valid_r) begin
          strobe_s  = 1'b1;
          chain_out = hold_r[bit_idx_r];
          // The final chain bit may sit below the top of the last word
          last_in_hold_s = (bit_idx_r == LAST_IDX) || (bits_r == FINAL_BIT);
        end else begin
          strobe_s       = 1'b0;
          last_in_hold_s = 1'b0;
        end
        word_ready = (words_r < NW_CNT) && (!hold_valid_r || last_in_hold_s);
        if (strobe_s && (bits_r == FINAL_BIT)) begin
          next_state_s = FINISH;
        end else begin
          next_state_s = LOAD;
        end
      end
      FINISH: begin
        busy         = 1'b1;
        done         = 1'b1;
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  assign chain_shift = strobe_s;
  assign accept_s    = word_valid && word_ready;
  assign error       = error_r;

  // Holding buffer, bit/word counters and sticky readback error
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_r       <= '0;
      hold_valid_r <= 1'b0;
      bit_idx_r    <= '0;
      words_r      <= '0;
      bits_r       <= '0;
      error_r      <= 1'b0;
    end else if ((state_r == IDLE) && start) begin
      hold_valid_r <= 1'b0;
      bit_idx_r    <= '0;
      words_r      <= '0;
      bits_r       <= '0;
      error_r      <= 1'b0;
    end else begin
      if (strobe_s) begin
        bits_r <= bits_r + BCW'(1);
        if (chain_ret) begin
          error_r <= 1'b1;
        end else begin
          error_r <= error_r;
        end
        if (last_in_hold_s) begin
          hold_valid_r <= 1'b0;
          bit_idx_r    <= '0;
        end else begin
          bit_idx_r <= bit_idx_r + BIW'(1);
        end
      end else begin
        bits_r <= bits_r;
      end
      // A refill in the same cycle as the last bit overrides the empty/rewind above
      if (accept_s) begin
        hold_r       <= word_in;
        hold_valid_r <= 1'b1;
        bit_idx_r    <= '0;
        words_r      <= words_r + WCW'(1);
      end else begin
        words_r <= words_r;
      end
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// Self-checking bench for config_loader: a bit-queue reference and a behavioural
// model of the configuration chain, with randomized words, gaps and restarts.
module tb_config_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, word_valid, chain_ret;
  logic [31:0] word_in;
  logic        word_ready, chain_out, chain_shift, chain_reset, busy, done, error;

  logic        start_b, word_valid_b, chain_ret_b;
  logic [31:0] word_in_b;
  logic        word_ready_b, chain_out_b, chain_shift_b, chain_reset_b, busy_b, done_b, error_b;

  int          tests = 0;
  int          fails = 0;
  logic [39:0] chain_model = 40'hFF_FFFF_FFFF;

  always #5 clk = ~clk;

  config_loader #(.WORD(32), .CHAIN_LEN(40)) dut (
    .clk(clk), .reset(reset), .start(start), .word_in(word_in), .word_valid(word_valid),
    .word_ready(word_ready), .chain_out(chain_out), .chain_shift(chain_shift),
    .chain_reset(chain_reset), .chain_ret(chain_ret), .busy(busy), .done(done), .error(error)
  );

  config_loader #(.WORD(32), .CHAIN_LEN(32)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .word_in(word_in_b), .word_valid(word_valid_b),
    .word_ready(word_ready_b), .chain_out(chain_out_b), .chain_shift(chain_shift_b),
    .chain_reset(chain_reset_b), .chain_ret(chain_ret_b), .busy(busy_b), .done(done_b),
    .error(error_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One load on the 40-bit chain; words w0 then w1 (low 8 bits used).
  task automatic run_load(input string tag, input logic [31:0] w0, input logic [31:0] w1,
                          input int gap, input bit restart, input bit fault, input bit abort);
    logic [39:0] exp_bits;
    logic [39:0] got_bits;
    int cyc, strobes, accepted, stalls, gap_used, done_cyc, err_first, widx, bad_out;
    bit finished;
    exp_bits = {w1[7:0], w0};
    got_bits = '0;
    cyc = 0; strobes = 0; accepted = 0; stalls = 0; gap_used = 0;
    done_cyc = -1; err_first = -1; widx = 0; bad_out = 0; finished = 1'b0;

    start = 1'b1;
    word_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".clear"}, {60'd0, chain_reset, busy, chain_shift, error}, 64'b1100);

    while (cyc <= 300 && !finished) begin
      start = (restart && strobes == 10) ? 1'b1 : 1'b0;
      if (widx >= 2) begin
        word_valid = 1'b1;
        word_in    = 32'hDEAD_BEEF;
      end else if (widx == 1 && word_ready && gap_used < gap) begin
        word_valid = 1'b0;
        gap_used++;
      end else begin
        word_valid = 1'b1;
        word_in    = (widx == 0) ? w0 : w1;
      end
      chain_ret = chain_model[0] | (fault && chain_shift && strobes == 2);

      if (error && err_first < 0) err_first = cyc;
      if (chain_reset) chain_model = '0;
      if (chain_shift) begin
        if (strobes < 40) got_bits[strobes] = chain_out;
        chain_model = {chain_out, chain_model[39:1]};
        strobes++;
      end else if (chain_out !== 1'b0) begin
        bad_out++;
      end
      if (busy && !chain_shift && !done && strobes > 0) stalls++;
      if (word_valid && word_ready) begin
        accepted++;
        widx++;
      end
      if (done) begin
        finished = 1'b1;
        done_cyc = cyc;
      end
      if (abort && strobes == 17) begin
        reset    = 1'b1;
        finished = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;

    chk({tag, ".finished"}, {63'd0, finished}, 64'd1);
    if (abort) begin
      chk({tag, ".abort_strobes"}, strobes, 64'd17);
      chk({tag, ".abort_outputs"},
          {59'd0, busy, chain_shift, word_ready, done, chain_reset}, 64'd0);
      reset = 1'b0;
      word_valid = 1'b0;
      @(negedge clk);
    end else begin
      chk({tag, ".done_cycle"}, done_cyc, 64'(42 + gap));
      chk({tag, ".strobes"}, strobes, 64'd40);
      chk({tag, ".bit_seq"}, {24'd0, got_bits}, {24'd0, exp_bits});
      chk({tag, ".chain"}, {24'd0, chain_model}, {24'd0, exp_bits});
      chk({tag, ".accepted"}, accepted, 64'd2);
      chk({tag, ".stalls"}, stalls, 64'(gap));
      chk({tag, ".idle_out"}, bad_out, 64'd0);
      chk({tag, ".err_first"}, err_first, fault ? 64'd5 : 64'hFFFF_FFFF_FFFF_FFFF);
      chk({tag, ".back_idle"}, {60'd0, busy, done, chain_shift, word_ready}, 64'd0);
      chk({tag, ".err_sticky"}, {63'd0, error}, {63'd0, fault});
      word_valid = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] wb, gb;
    int cyc, sb, acc, ready_after, dc;
    bit fin;

    reset = 1'b1;
    start = 1'b0; word_valid = 1'b0; word_in = '0; chain_ret = 1'b0;
    start_b = 1'b0; word_valid_b = 1'b0; word_in_b = '0; chain_ret_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_a", {57'd0, word_ready, chain_out, chain_shift, chain_reset, busy, done, error}, 64'd0);
    chk("reset_b", {57'd0, word_ready_b, chain_out_b, chain_shift_b, chain_reset_b, busy_b,
                    done_b, error_b}, 64'd0);
    start = 1'b1;
    @(negedge clk);
    chk("start_in_reset", {62'd0, busy, chain_reset}, 64'd0);
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    run_load("basic", 32'hA5A5_A5A5, 32'h0000_00C3, 0, 1'b0, 1'b0, 1'b0);
    chk("basic.chain_const", {24'd0, chain_model}, 64'h00_C3A5_A5A5_A5);
    run_load("gap", 32'hA5A5_A5A5, 32'h0000_00C3, 5, 1'b0, 1'b0, 1'b0);
    run_load("fault", $urandom, $urandom, 0, 1'b0, 1'b1, 1'b0);
    run_load("restart", $urandom, $urandom, 0, 1'b1, 1'b0, 1'b0);
    run_load("abort", $urandom, $urandom, 0, 1'b0, 1'b0, 1'b1);
    run_load("post_abort", $urandom, $urandom, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_load("rand", $urandom, $urandom, int'($urandom_range(0, 6)),
               1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    // Exact-multiple configuration: one word, 32 strobes
    wb = $urandom;
    gb = '0;
    cyc = 0; sb = 0; acc = 0; ready_after = 0; dc = -1; fin = 1'b0;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    while (cyc <= 200 && !fin) begin
      word_valid_b = 1'b1;
      word_in_b    = (acc == 0) ? wb : 32'h1234_5678;
      if (chain_shift_b) begin
        if (sb < 32) gb[sb] = chain_out_b;
        sb++;
      end
      if (acc > 0 && word_ready_b) ready_after++;
      if (word_valid_b && word_ready_b) acc++;
      if (done_b) begin
        fin = 1'b1;
        dc  = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    word_valid_b = 1'b0;
    chk("exact.finished", {63'd0, fin}, 64'd1);
    chk("exact.done_cycle", dc, 64'd34);
    chk("exact.strobes", sb, 64'd32);
    chk("exact.bit_seq", {32'd0, gb}, {32'd0, wb});
    chk("exact.accepted", acc, 64'd1);
    chk("exact.ready_after", ready_after, 64'd0);
    chk("exact.idle", {62'd0, busy_b, error_b}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
